polar_encoder: RTL and testbench

Iterative polar encoder computing x = u·G_N, where G_N is the N-fold Kronecker power of [[1,0],[1,1]], for N = 8…256. It is the transmit-side counterpart of the SC decoder's partial-sum combine path and uses the same bit ordering: higher indices form the "left" half, and hi = hi ^ lo. A 256-bit codeword register is updated by one butterfly stage per cycle. Input and output use valid/ready handshakes, and the block feeds the channel/test harness that drives the decoder.

---
 rtl/polar_pkg.sv | 29 ++
 rtl/polar_encoder_if.sv | 33 +++
 rtl/polar_enc_stage.sv | 25 ++
 rtl/polar_encoder.sv | 79 +++++++
 tb/tb_polar_encoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/polar_pkg.sv
// Shared constants, code-length codes, FSM state type and length-mask helper
// for the iterative polar encoder.
package polar_pkg;

    localparam int MAXN      = 256;
    localparam int MAXSTAGES = 8;

    // Code-length select values; same numbering as the decoder combine stage codes.
    localparam logic [2:0] N8   = 3'd0;
    localparam logic [2:0] N16  = 3'd1;
    localparam logic [2:0] N32  = 3'd2;
    localparam logic [2:0] N64  = 3'd3;
    localparam logic [2:0] N128 = 3'd4;
    localparam logic [2:0] N256 = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Codes 6 and 7 alias the largest length.
    function automatic logic [2:0] n_sel_eff(input logic [2:0] n_sel);
        return (n_sel > N256) ? N256 : n_sel;
    endfunction

    function automatic logic [MAXN-1:0] lenmask(input logic [2:0] n_sel);
        logic [MAXN-1:0] m;
        m = '1;
        return m >> (MAXN - (8 << n_sel_eff(n_sel)));
    endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// Handshake/data bundle of polar_encoder. The optional frozen_mask field
// exists only when POLAR_ENC_FROZEN_MASK_EN is defined.
interface polar_encoder_if;
    import polar_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds data stable while valid is high and not yet taken.
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      n_sel;
    logic [MAXN-1:0] u_in;
`ifdef POLAR_ENC_FROZEN_MASK_EN
    logic [MAXN-1:0] frozen_mask;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [MAXN-1:0] x_out;
    logic            busy;
    state_t          state_dbg;

`ifdef POLAR_ENC_FROZEN_MASK_EN
    modport slave (input in_valid, n_sel, u_in, frozen_mask, out_ready,
                   output in_ready, out_valid, x_out, busy, state_dbg);
    modport master (output in_valid, n_sel, u_in, frozen_mask, out_ready,
                    input in_ready, out_valid, x_out, busy, state_dbg);
`else
    modport slave (input in_valid, n_sel, u_in, out_ready,
                   output in_ready, out_valid, x_out, busy, state_dbg);
    modport master (output in_valid, n_sel, u_in, out_ready,
                    input in_ready, out_valid, x_out, busy, state_dbg);
`endif

endinterface

// File: rtl/polar_enc_stage.sv
// One combinational butterfly layer: within every 2^(s+1)-bit block the upper
// half is XORed with the lower half, the lower half passes through.
module polar_enc_stage
    import polar_pkg::*;
(
    input  logic [MAXN-1:0] d_in,
    input  logic [2:0]      stage,
    output logic [MAXN-1:0] d_out
);

    logic [MAXN-1:0] layer [MAXSTAGES];

    for (genvar s = 0; s < MAXSTAGES; s++) begin : gen_s
        for (genvar i = 0; i < MAXN; i++) begin : gen_i
            if (((i >> s) & 1) == 1) begin : gen_hi
                assign layer[s][i] = d_in[i] ^ d_in[i - (1 << s)];
            end else begin : gen_lo
                assign layer[s][i] = d_in[i];
            end
        end
    end

    assign d_out = layer[stage];

endmodule

// File: rtl/polar_encoder.sv
// Iterative polar encoder x = u*G_N, N = 8..256, one butterfly stage per cycle.
// Optional feature macro: POLAR_ENC_FROZEN_MASK_EN (adds frozen_mask input).
module polar_encoder
    import polar_pkg::*;
(
    input logic           clk,
    input logic           rst,
    polar_encoder_if.slave bus
);

    state_t          state, state_nxt;
    logic [2:0]      stage_cnt;
    logic [2:0]      last_stage;
    logic [MAXN-1:0] cw, cw_stage, cw_load;

    polar_enc_stage u_stage (
        .d_in  (cw),
        .stage (stage_cnt),
        .d_out (cw_stage)
    );

    // Bits at or above N are cleared here so no stage ever pulls them non-zero.
`ifdef POLAR_ENC_FROZEN_MASK_EN
    assign cw_load = bus.u_in & ~bus.frozen_mask & lenmask(bus.n_sel);
`else
    assign cw_load = bus.u_in & lenmask(bus.n_sel);
`endif

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = ~rst;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (stage_cnt == last_stage) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stage_cnt  <= 3'd0;
            last_stage <= 3'd0;
            cw         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cw         <= cw_load;
                        stage_cnt  <= 3'd0;
                        last_stage <= 3'd2 + n_sel_eff(bus.n_sel);
                    end
                end
                RUN: begin
                    cw        <= cw_stage;
                    stage_cnt <= stage_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.x_out     = cw;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed vectors, stall, intrusion,
// reset abort and random vectors against a subset-sum reference model.
module tb_polar_encoder;
    import polar_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    polar_encoder_if bif ();

    polar_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    logic [MAXN-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [MAXN-1:0] got, input logic [MAXN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // x[j] is the XOR of u[i] over all i whose set bits are a subset of j's.
    function automatic logic [MAXN-1:0] ref_enc(input logic [2:0] n, input logic [MAXN-1:0] u,
                                                input logic [MAXN-1:0] mask);
        logic [MAXN-1:0] um;
        logic [MAXN-1:0] x;
        logic b;
        int nn;
        nn = 8 << ((n > 3'd5) ? 5 : int'(n));
        um = u & ~mask;
        x  = '0;
        for (int j = 0; j < nn; j++) begin
            b = 1'b0;
            for (int i = 0; i <= j; i++)
                if ((i & ~j) == 0) b ^= um[i];
            x[j] = b;
        end
        return x;
    endfunction

    function automatic int lat_of(input logic [2:0] n);
        return 3 + ((n > 3'd5) ? 5 : int'(n));
    endfunction

    task automatic send(input logic [2:0] n, input logic [MAXN-1:0] u,
                        input logic [MAXN-1:0] mask, input logic [MAXN-1:0] exp);
        int k;
        k = 0;
        @(negedge clk);
        while (!bif.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bif.in_ready) check("in_ready_timeout", 0, 1);
        bif.in_valid = 1'b1;
        bif.n_sel    = n;
        bif.u_in     = u;
`ifdef POLAR_ENC_FROZEN_MASK_EN
        bif.frozen_mask = mask;
`else
        if (mask != '0) check("mask_unsupported", 1, 0);
`endif
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_cyc      = cyc_cnt;
        bif.in_valid = 1'b0;
        bif.u_in     = {8{$urandom}};
        bif.n_sel    = 3'($urandom_range(0, 7));
        check("busy_after_accept", bif.busy, 1);
    endtask

    task automatic collect(input int lat_exp, input bit stall);
        int k;
        logic [MAXN-1:0] exp;
        k = 0;
        bif.out_ready = ~stall;
        @(negedge clk);
        while (!bif.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bif.out_valid) begin
            check("out_valid_timeout", 0, 1);
            bif.out_ready = 1'b1;
            return;
        end
        check("latency", cyc_cnt - acc_cyc, lat_exp);
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("x_out", bif.x_out, exp);
        check("in_ready_in_done", bif.in_ready, 0);
        if (stall) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("stall_valid", bif.out_valid, 1);
                check("stall_x_out", bif.x_out, exp);
                check("stall_in_ready", bif.in_ready, 0);
            end
            bif.out_ready = 1'b1;
            #1 check("in_ready_handshake_cycle", bif.in_ready, 0);
        end
        @(negedge clk);
        check("in_ready_after_hs", bif.in_ready, 1);
        check("out_valid_after_hs", bif.out_valid, 0);
        bif.out_ready = 1'b1;
    endtask

    task automatic run_txn(input logic [2:0] n, input logic [MAXN-1:0] u,
                           input logic [MAXN-1:0] mask, input logic [MAXN-1:0] exp, input bit stall);
        send(n, u, mask, exp);
        collect(lat_of(n), stall);
    endtask

    initial begin
        logic [MAXN-1:0] ones;
        logic [MAXN-1:0] u;
        logic [MAXN-1:0] low8;
        logic [2:0] n;
        bit seen;

        ones = '1;
        low8 = 256'hFF;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        bif.n_sel     = 3'd0;
        bif.u_in      = '0;
`ifdef POLAR_ENC_FROZEN_MASK_EN
        bif.frozen_mask = '0;
`endif

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bif.in_ready, 0);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_x_out", bif.x_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bif.in_ready, 1);

        // Directed vectors; upper garbage bits in u must be ignored.
        run_txn(N8, 256'h01, '0, 256'hFF, 1'b0);
        run_txn(N8, {248'hA5A5_1234, 8'h80}, '0, 256'h80, 1'b0);
        run_txn(N8, ones, '0, 256'h01, 1'b0);
        run_txn(N256, 256'h1, '0, ones, 1'b0);
        run_txn(N256, ones, '0, 256'h1, 1'b0);
        run_txn(N32, ones, '0, 256'h1, 1'b0);
        run_txn(3'd7, 256'h1, '0, ones, 1'b0);
        run_txn(3'd6, ones, '0, 256'h1, 1'b0);

        // Output stall with a 16-bit code.
        u = 256'h8001;
        run_txn(N16, u, '0, ref_enc(N16, u, '0), 1'b1);

        // A second request during RUN must be refused.
        u = 256'h0123_4567_89AB_CDEF;
        send(N256, u, '0, ref_enc(N256, u, '0));
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.u_in     = ones;
        bif.n_sel    = N8;
        for (int c = 0; c < 3; c++) begin
            check("in_ready_during_run", bif.in_ready, 0);
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        collect(8, 1'b0);

        // Reset in the 4th RUN cycle aborts the transfer.
        send(N256, 256'h1, '0, ones);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_x_out", bif.x_out, 0);
        check("abort_out_valid", bif.out_valid, 0);
        check("abort_busy", bif.busy, 0);
        check("abort_in_ready", bif.in_ready, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bif.out_valid) seen = 1'b1;
        end
        check("abort_no_output", seen, 0);
        check("abort_x_out_held", bif.x_out, 0);
        run_txn(N8, 256'h01, '0, 256'hFF, 1'b0);

`ifdef POLAR_ENC_FROZEN_MASK_EN
        run_txn(N8, low8, 256'hFE, 256'hFF, 1'b0);
`else
        run_txn(N8, low8, '0, 256'h01, 1'b0);
`endif

        for (int r = 0; r < 50; r++) begin
            for (int k = 0; k < 8; k++) u[k*32 +: 32] = $urandom;
            n = 3'($urandom_range(0, 7));
            run_txn(n, u, '0, ref_enc(n, u, '0), 1'b0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
